cond_eval_unit: RTL and testbench
=================================

Name: cond_eval_unit

Overview:
- Registered, handshaked successor to the combinational condition tester.
- Evaluates Bicc, optional FBfcc, and Ticc conditions.
- Checks supervisor-only instructions.
- Tracks delay-slot annulment across instructions and holds trap requests until the trap unit acknowledges them.
- Sits between decode and the control unit's next-PC/trap logic.

Parameters:
HAS_FCC, 1, 1 = decode FBfcc (op=00, op2=110) using fcc; 0 = FBfcc treated as non-branch
TT_W, 8, width of trap type output

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
in_valid  in  1  ir/icc/fcc/s/et valid
in_ready  out  1  unit can accept an instruction
ir  in  32  instruction word
icc  in  4  {N,Z,V,C} at [3:0]
fcc  in  2  0=E 1=L 2=G 3=U
s  in  1  supervisor mode
et  in  1  traps enabled
out_valid  out  1  result registers valid
out_ready  in  1  consumer takes result
cond  out  1  condition true (branch taken / trap taken / instruction permitted)
is_branch  out  1  result is Bicc/FBfcc
annulled  out  1  this instruction was in an annulled delay slot; suppress it
trap_req  out  1  trap pending
trap_tt  out  TT_W  trap type
err_mode  out  1  one-result flag: trap taken with et=0

Behaviour:
- Clock and reset: one clock clk. Reset is asynchronous, active-high.
  - Reset clears state to RUN and annul_pend to 0.
  - All outputs go to 0, except in_ready, which is combinational and goes to 1.
- Accept and output:
  - Accept occurs when in_valid & in_ready.
  - Result registers load on the next edge, one-cycle latency.
  - in_ready = (state==RUN) & (~out_valid | out_ready).
  - out_valid holds with stable outputs until out_ready.
  - Accept and drain can happen in the same cycle.
- Decode:
  - op=ir[31:30], a=ir[29], cc=ir[28:25], op2=ir[24:22], op3=ir[24:19].
  - Bicc: op=00, op2=010. Ticc: op=10, op3=111010.
  - Privileged: op=10, op3 in {101001,101010,101011,110001,110010,110011}.
- icc table (N=icc[3], Z=icc[2], V=icc[1], C=icc[0]):
  - 1000 always; 0000 never
  - 1001 ~Z; 0001 Z
  - 1010 ~(Z|(N^V)); 0010 Z|(N^V)
  - 1011 ~(N^V); 0011 N^V
  - 1100 ~(C|Z); 0100 C|Z
  - 1101 ~C; 0101 C
  - 1110 ~N; 0110 N
  - 1111 ~V; 0111 V
- fcc table:
  - 1000 always; 0000 never
  - 0111 U; 0110 G; 0101 G|U; 0100 L; 0011 L|U; 0010 L|G; 0001 L|G|U
  - 1001 E; 1010 E|U; 1011 E|G; 1100 E|G|U; 1101 E|L; 1110 E|L|U; 1111 E|L|G
- Annul FSM, internal annul_pend flag:
  - Set it when an accepted, non-annulled branch has a=1 and either cc=1000 or cond=0.
  - The next accepted instruction outputs annulled=1, cond=0, is_branch=0, no trap, no fault, and clears annul_pend.
  - A branch with a=0, or a taken conditional branch with a=1, leaves annul_pend=0.
- Trap FSM, states RUN and TRAP_WAIT:
  - Ticc with cond=1 and et=1: trap_req=1, trap_tt={1'b1,ir[6:0]}, zero-extended to TT_W. Enter TRAP_WAIT.
  - Ticc with cond=1 and et=0: output cond=0, err_mode=1, no trap_req.
  - Privileged instruction with s=0: cond=0, trap_req=1, trap_tt=0x03. Enter TRAP_WAIT.
  - In TRAP_WAIT, in_ready=0. trap_req and trap_tt hold until trap_ack=1.
  - trap_ack=1 clears trap_req and annul_pend and returns to RUN. in_ready is asserted the next cycle.
- Other instructions: cond=1, is_branch=0.
- trap_ack while not in TRAP_WAIT is ignored.
- out_ready and trap_ack may both be high in one cycle; both take effect.
- Reset mid-TRAP_WAIT or mid-slot drops all pending state.
- fcc is ignored when HAS_FCC=0.

Test Plan:
- be (ir=0x02800004), icc=0100 -> next cycle out_valid=1, cond=1, is_branch=1, annulled=0.
- bne,a (ir=0x32800004), icc=0100, followed by any instruction -> first result cond=0; second result annulled=1, cond=0.
- ba,a (ir=0x30800004) then ta 5 (ir=0x91D02005) -> branch cond=1; ta annulled=1, trap_req stays 0.
- ta 5 (ir=0x91D02005), et=1 -> trap_req=1, trap_tt=0x85, in_ready=0 for 3 cycles; trap_ack -> trap_req=0, in_ready=1 next cycle.
- rdpsr (ir=0x81480000), s=0 -> cond=0, trap_tt=0x03. With s=1 -> cond=1, no trap.
- fbug (ir=0x0B800004), fcc=3 -> cond=1. With HAS_FCC=0 -> is_branch=0. out_ready held low 4 cycles -> outputs stable, in_ready=0; assert reset mid-hold -> all outputs 0.

Source files
------------

// File: rtl/cond_eval_unit.sv
// Registered condition evaluator for Bicc/FBfcc/Ticc and privileged-op checks.
// Tracks annulled delay slots and holds trap requests until the trap unit acks.
module cond_eval_unit #(
    parameter int HAS_FCC = 1,
    parameter int TT_W    = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     ir,
    input  logic [3:0]      icc,
    input  logic [1:0]      fcc,
    input  logic            s,
    input  logic            et,
    output logic            out_valid,
    input  logic            out_ready,
    input  logic            trap_ack,
    output logic            cond,
    output logic            is_branch,
    output logic            annulled,
    output logic            trap_req,
    output logic [TT_W-1:0] trap_tt,
    output logic            err_mode
);

    typedef enum logic {RUN = 1'b0, TRAP_WAIT = 1'b1} state_t;

    typedef struct packed {
        logic            cond;
        logic            is_branch;
        logic            annulled;
        logic            err_mode;
        logic [TT_W-1:0] tt;
    } res_t;

    state_t state_q, state_d;
    res_t   res_q, res_d;
    logic   annul_pend, annul_d;
    logic   trap_q, trap_set;
    logic   accept, ack;

    // Instruction fields
    logic [1:0] op;
    logic       a;
    logic [3:0] cc;
    logic [2:0] op2;
    logic [5:0] op3;
    logic       is_bicc, is_fbfcc, is_ticc, is_priv;
    logic       unused_ir;

    assign op        = ir[31:30];
    assign a         = ir[29];
    assign cc        = ir[28:25];
    assign op2       = ir[24:22];
    assign op3       = ir[24:19];
    assign unused_ir = ^ir[18:7];

    assign is_bicc  = (op == 2'b00) && (op2 == 3'b010);
    assign is_fbfcc = (HAS_FCC != 0) && (op == 2'b00) && (op2 == 3'b110);
    assign is_ticc  = (op == 2'b10) && (op3 == 6'b111010);

    always_comb begin
        is_priv = 1'b0;
        if (op == 2'b10) begin
            case (op3)
                6'b101001, 6'b101010, 6'b101011,
                6'b110001, 6'b110010, 6'b110011: is_priv = 1'b1;
                default:                         is_priv = 1'b0;
            endcase
        end
    end

    // Each table's upper half is the complement of its lower half, so evaluate
    // the cc[2:0] base term and flip it with cc[3].
    logic n_f, z_f, v_f, c_f;
    logic icc_base, icc_true;
    logic f_e, f_l, f_g, f_u;
    logic fcc_base, fcc_true;

    assign n_f = icc[3];
    assign z_f = icc[2];
    assign v_f = icc[1];
    assign c_f = icc[0];

    always_comb begin
        case (cc[2:0])
            3'd0:    icc_base = 1'b0;
            3'd1:    icc_base = z_f;
            3'd2:    icc_base = z_f | (n_f ^ v_f);
            3'd3:    icc_base = n_f ^ v_f;
            3'd4:    icc_base = c_f | z_f;
            3'd5:    icc_base = c_f;
            3'd6:    icc_base = n_f;
            default: icc_base = v_f;
        endcase
    end
    assign icc_true = icc_base ^ cc[3];

    assign f_e = (fcc == 2'd0);
    assign f_l = (fcc == 2'd1);
    assign f_g = (fcc == 2'd2);
    assign f_u = (fcc == 2'd3);

    always_comb begin
        case (cc[2:0])
            3'd0:    fcc_base = 1'b0;
            3'd1:    fcc_base = f_l | f_g | f_u;
            3'd2:    fcc_base = f_l | f_g;
            3'd3:    fcc_base = f_l | f_u;
            3'd4:    fcc_base = f_l;
            3'd5:    fcc_base = f_g | f_u;
            3'd6:    fcc_base = f_g;
            default: fcc_base = f_u;
        endcase
    end
    assign fcc_true = fcc_base ^ cc[3];

    // Result for the instruction presented this cycle
    logic br_true;

    always_comb begin
        res_d    = '0;
        annul_d  = 1'b0;
        trap_set = 1'b0;
        br_true  = is_fbfcc ? fcc_true : icc_true;
        if (annul_pend) begin
            res_d.annulled = 1'b1;
        end else if (is_bicc || is_fbfcc) begin
            res_d.is_branch = 1'b1;
            res_d.cond      = br_true;
            // ba,a annuls its slot even though taken
            annul_d         = a & ((cc == 4'b1000) | ~br_true);
        end else if (is_ticc) begin
            if (icc_true && et) begin
                res_d.cond = 1'b1;
                res_d.tt   = TT_W'({1'b1, ir[6:0]});
                trap_set   = 1'b1;
            end else begin
                res_d.err_mode = icc_true;
            end
        end else if (is_priv && !s) begin
            res_d.tt = TT_W'(8'h03);
            trap_set = 1'b1;
        end else begin
            res_d.cond = 1'b1;
        end
    end

    // Trap FSM: next state and handshake
    always_comb begin
        state_d  = state_q;
        in_ready = (state_q == RUN) && (!out_valid || out_ready);
        accept   = in_valid && in_ready;
        ack      = (state_q == TRAP_WAIT) && trap_ack;
        case (state_q)
            RUN:       if (accept && trap_set) state_d = TRAP_WAIT;
            TRAP_WAIT: if (trap_ack) state_d = RUN;
            default:   state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            res_q      <= '0;
            annul_pend <= 1'b0;
            trap_q     <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                res_q      <= res_d;
                annul_pend <= annul_d;
                trap_q     <= trap_set;
                out_valid  <= 1'b1;
            end else begin
                if (out_ready) out_valid <= 1'b0;
                if (ack) begin
                    trap_q     <= 1'b0;
                    annul_pend <= 1'b0;
                end
            end
        end
    end

    assign cond      = res_q.cond;
    assign is_branch = res_q.is_branch;
    assign annulled  = res_q.annulled;
    assign err_mode  = res_q.err_mode;
    assign trap_tt   = res_q.tt;
    assign trap_req  = trap_q;

endmodule

// File: tb/tb_cond_eval_unit.sv
// Bench for cond_eval_unit: HAS_FCC=1 and HAS_FCC=0 instances share stimulus;
// a flag-level model is checked every cycle alongside literal directed checks.
module tb_cond_eval_unit;
    localparam int TT_W = 8;

    logic clk = 1'b0;
    logic reset, in_valid, out_ready, trap_ack, s, et;
    logic [31:0] ir;
    logic [3:0]  icc;
    logic [1:0]  fcc;
    logic [1:0]  in_ready, out_valid, cond, is_branch, annulled, trap_req, err_mode;
    logic [TT_W-1:0] trap_tt [2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cond_eval_unit #(.HAS_FCC(1), .TT_W(TT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[0]),
        .ir(ir), .icc(icc), .fcc(fcc), .s(s), .et(et),
        .out_valid(out_valid[0]), .out_ready(out_ready), .trap_ack(trap_ack),
        .cond(cond[0]), .is_branch(is_branch[0]), .annulled(annulled[0]),
        .trap_req(trap_req[0]), .trap_tt(trap_tt[0]), .err_mode(err_mode[0])
    );

    cond_eval_unit #(.HAS_FCC(0), .TT_W(TT_W)) dut_nofcc (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[1]),
        .ir(ir), .icc(icc), .fcc(fcc), .s(s), .et(et),
        .out_valid(out_valid[1]), .out_ready(out_ready), .trap_ack(trap_ack),
        .cond(cond[1]), .is_branch(is_branch[1]), .annulled(annulled[1]),
        .trap_req(trap_req[1]), .trap_tt(trap_tt[1]), .err_mode(err_mode[1])
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit icc_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, v, y;
        n = f[3]; z = f[2]; v = f[1]; y = f[0];
        case (c)
            4'b1000: return 1'b1;           4'b0000: return 1'b0;
            4'b1001: return !z;             4'b0001: return z;
            4'b1010: return !(z | (n ^ v)); 4'b0010: return z | (n ^ v);
            4'b1011: return !(n ^ v);       4'b0011: return n ^ v;
            4'b1100: return !(y | z);       4'b0100: return y | z;
            4'b1101: return !y;             4'b0101: return y;
            4'b1110: return !n;             4'b0110: return n;
            4'b1111: return !v;             default: return v;
        endcase
    endfunction

    function automatic bit fcc_ok(input logic [3:0] c, input logic [1:0] f);
        bit e, l, g, u;
        e = (f == 0); l = (f == 1); g = (f == 2); u = (f == 3);
        case (c)
            4'd8:  return 1'b1;      4'd0:  return 1'b0;
            4'd7:  return u;         4'd6:  return g;
            4'd5:  return g | u;     4'd4:  return l;
            4'd3:  return l | u;     4'd2:  return l | g;
            4'd1:  return l | g | u; 4'd9:  return e;
            4'd10: return e | u;     4'd11: return e | g;
            4'd12: return e | g | u; 4'd13: return e | l;
            4'd14: return e | l | u; default: return e | l | g;
        endcase
    endfunction

    typedef struct {
        bit ov, tw, pend, trap, cond, br, ann, err;
        logic [7:0] tt;
    } mst_t;

    mst_t ms [2];

    function automatic mst_t m_next(input mst_t m, input bit has_fcc);
        mst_t r;
        bit rdy, t, priv;
        logic [5:0] op3;
        r    = m;
        rdy  = !m.tw && (!m.ov || out_ready);
        op3  = ir[24:19];
        priv = (ir[31:30] == 2'b10) && (op3 inside {6'h29, 6'h2a, 6'h2b, 6'h31, 6'h32, 6'h33});
        if (m.tw && trap_ack) begin
            r.tw = 0; r.trap = 0; r.pend = 0;
        end
        if (m.ov && out_ready) r.ov = 0;
        if (in_valid && rdy) begin
            r.ov = 1; r.cond = 0; r.br = 0; r.ann = 0; r.err = 0;
            r.trap = 0; r.tt = 8'h00; r.pend = 0;
            if (m.pend) begin
                r.ann = 1;
            end else if (ir[31:30] == 2'b00 &&
                         (ir[24:22] == 3'b010 || (has_fcc && ir[24:22] == 3'b110))) begin
                t = (ir[24:22] == 3'b010) ? icc_ok(ir[28:25], icc) : fcc_ok(ir[28:25], fcc);
                r.br   = 1;
                r.cond = t;
                r.pend = ir[29] && (ir[28:25] == 4'b1000 || !t);
            end else if (ir[31:30] == 2'b10 && op3 == 6'b111010) begin
                if (icc_ok(ir[28:25], icc)) begin
                    if (et) begin
                        r.cond = 1; r.trap = 1; r.tw = 1;
                        r.tt = 8'h80 + {1'b0, ir[6:0]};
                    end else begin
                        r.err = 1;
                    end
                end
            end else if (priv && !s) begin
                r.trap = 1; r.tw = 1; r.tt = 8'h03;
            end else begin
                r.cond = 1;
            end
        end
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) ms[k] <= '{default: 0};
        end else begin
            for (int k = 0; k < 2; k++) ms[k] <= m_next(ms[k], k == 0);
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("m.in_ready[%0d]", k), in_ready[k], !ms[k].tw && (!ms[k].ov || out_ready));
                chk($sformatf("m.out_valid[%0d]", k), out_valid[k], ms[k].ov);
                chk($sformatf("m.trap_req[%0d]", k), trap_req[k], ms[k].trap);
                if (ms[k].trap) chk($sformatf("m.trap_tt[%0d]", k), trap_tt[k], ms[k].tt);
                if (ms[k].ov) begin
                    chk($sformatf("m.cond[%0d]", k), cond[k], ms[k].cond);
                    chk($sformatf("m.is_branch[%0d]", k), is_branch[k], ms[k].br);
                    chk($sformatf("m.annulled[%0d]", k), annulled[k], ms[k].ann);
                    chk($sformatf("m.err_mode[%0d]", k), err_mode[k], ms[k].err);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    localparam logic [31:0] BE    = 32'h0280_0004;
    localparam logic [31:0] BNE_A = 32'h3280_0004;
    localparam logic [31:0] BA_A  = 32'h3080_0004;
    localparam logic [31:0] TA5   = 32'h91D0_2005;
    localparam logic [31:0] TNE5  = 32'h93D0_2005;
    localparam logic [31:0] RDPSR = 32'h8148_0000;
    localparam logic [31:0] FBUG  = 32'h0B80_0004;
    localparam logic [31:0] NOP   = 32'h0100_0000;

    function automatic logic [31:0] bicc(input logic a, input logic [3:0] c);
        return {2'b00, a, c, 3'b010, 22'd4};
    endfunction

    function automatic logic [31:0] fbfcc(input logic a, input logic [3:0] c);
        return {2'b00, a, c, 3'b110, 22'd4};
    endfunction

    // Called at posedge+1; returns at the posedge+1 after the accept edge.
    task automatic send(input logic [31:0] i, input logic [3:0] ic, input logic [1:0] fc,
                        input logic sv, input logic te);
        ir = i; icc = ic; fcc = fc; s = sv; et = te;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s.out_valid[%0d]", tag, k), out_valid[k], 0);
            chk($sformatf("%s.in_ready[%0d]", tag, k), in_ready[k], 1);
            chk($sformatf("%s.trap_req[%0d]", tag, k), trap_req[k], 0);
            chk($sformatf("%s.flags[%0d]", tag, k),
                {cond[k], is_branch[k], annulled[k], err_mode[k]}, 0);
            chk($sformatf("%s.trap_tt[%0d]", tag, k), trap_tt[k], 0);
        end
    endtask

    logic [15:0] imask, fmask;

    initial begin
        in_valid = 0; out_ready = 1; trap_ack = 0; s = 0; et = 0;
        ir = 32'h0; icc = 4'h0; fcc = 2'd0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #1 chk_reset_outputs("reset");
        step();
        reset = 1'b0;

        // be with Z=1
        send(BE, 4'b0100, 0, 1, 1);
        look();
        chk("be.out_valid", out_valid[0], 1);
        chk("be.cond", cond[0], 1);
        chk("be.is_branch", is_branch[0], 1);
        chk("be.annulled", annulled[0], 0);
        step();

        // bne,a not taken annuls next instruction
        send(BNE_A, 4'b0100, 0, 1, 1);
        look();
        chk("bne_a.cond", cond[0], 0);
        chk("bne_a.is_branch", is_branch[0], 1);
        step();
        send(NOP, 4'b0000, 0, 1, 1);
        look();
        chk("slot.annulled", annulled[0], 1);
        chk("slot.cond", cond[0], 0);
        chk("slot.is_branch", is_branch[0], 0);
        step();

        // ba,a annuls its slot; annulled ta does not trap
        send(BA_A, 4'b0000, 0, 1, 1);
        look();
        chk("ba_a.cond", cond[0], 1);
        step();
        send(TA5, 4'b0000, 0, 1, 1);
        look();
        chk("ta_slot.annulled", annulled[0], 1);
        chk("ta_slot.trap_req", trap_req[0], 0);
        chk("ta_slot.in_ready", in_ready[0], 1);
        step();

        // ta 5 with traps enabled: held until ack
        send(TA5, 4'b0000, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            look();
            chk("ta.trap_req", trap_req[0], 1);
            chk("ta.trap_tt", trap_tt[0], 8'h85);
            chk("ta.in_ready", in_ready[0], 0);
            step();
        end
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        look();
        chk("ack.trap_req", trap_req[0], 0);
        chk("ack.in_ready", in_ready[0], 1);
        step();

        // ta with traps disabled -> error mode; tne not taken -> plain cond=0
        send(TA5, 4'b0000, 0, 1, 0);
        look();
        chk("ta_et0.cond", cond[0], 0);
        chk("ta_et0.err_mode", err_mode[0], 1);
        chk("ta_et0.trap_req", trap_req[0], 0);
        step();
        send(TNE5, 4'b0100, 0, 1, 1);
        look();
        chk("tne.cond", cond[0], 0);
        chk("tne.err_mode", err_mode[0], 0);
        step();

        // trap_ack in RUN is ignored, even alongside a trapping accept
        trap_ack = 1'b1;
        send(TA5, 4'b0000, 0, 1, 1);
        trap_ack = 1'b0;
        look();
        chk("stray_ack.trap_req", trap_req[0], 1);
        chk("stray_ack.in_ready", in_ready[0], 0);
        step();
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;

        // rdpsr privilege check
        send(RDPSR, 4'b0000, 0, 0, 1);
        look();
        chk("rdpsr_u.cond", cond[0], 0);
        chk("rdpsr_u.trap_tt", trap_tt[0], 8'h03);
        chk("rdpsr_u.trap_req", trap_req[0], 1);
        step();
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        send(RDPSR, 4'b0000, 0, 1, 1);
        look();
        chk("rdpsr_s.cond", cond[0], 1);
        chk("rdpsr_s.trap_req", trap_req[0], 0);
        step();

        // fbug with fcc=U; HAS_FCC=0 instance sees a non-branch
        send(FBUG, 4'b0000, 2'd3, 1, 1);
        look();
        chk("fbug.cond", cond[0], 1);
        chk("fbug.is_branch", is_branch[0], 1);
        chk("fbug_nofcc.is_branch", is_branch[1], 0);
        chk("fbug_nofcc.cond", cond[1], 1);
        step();

        // every icc condition with N=1,Z=0,V=1,C=0
        imask = 16'h3FC0;
        for (int c = 0; c < 16; c++) begin
            send(bicc(1'b0, 4'(c)), 4'b1010, 0, 1, 1);
            look();
            chk($sformatf("icc_tbl[%0d]", c), cond[0], imask[c]);
            step();
        end

        // every fcc condition with fcc=L
        fmask = 16'hE11E;
        for (int c = 0; c < 16; c++) begin
            send(fbfcc(1'b0, 4'(c)), 4'b0000, 2'd1, 1, 1);
            look();
            chk($sformatf("fcc_tbl[%0d]", c), cond[0], fmask[c]);
            step();
        end

        // back-to-back accepts (accept and drain in one cycle)
        send(BE, 4'b0000, 0, 1, 1);
        send(NOP, 4'b0000, 0, 1, 1);
        look();
        chk("b2b.cond", cond[0], 1);
        chk("b2b.is_branch", is_branch[0], 0);
        step();

        // reset in annulled slot drops annul_pend
        send(BNE_A, 4'b0100, 0, 1, 1);
        look();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        send(NOP, 4'b0000, 0, 1, 1);
        look();
        chk("slot_rst.annulled", annulled[0], 0);
        chk("slot_rst.cond", cond[0], 1);
        step();

        // reset in TRAP_WAIT
        send(TA5, 4'b0000, 0, 1, 1);
        look();
        chk("tw_rst.pre", trap_req[0], 1);
        step();
        reset = 1'b1;
        #2 chk_reset_outputs("tw_rst");
        step();
        reset = 1'b0;
        step();

        // backpressure hold with a competing request, then reset mid-hold
        out_ready = 1'b0;
        send(BE, 4'b0100, 0, 1, 1);
        ir = NOP; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            look();
            chk("hold.out_valid", out_valid[0], 1);
            chk("hold.cond", cond[0], 1);
            chk("hold.is_branch", is_branch[0], 1);
            chk("hold.in_ready", in_ready[0], 0);
            step();
        end
        reset = 1'b1;
        #2 chk_reset_outputs("hold_rst");
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        reset = 1'b0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
